display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_pkg.sv | 38 +++
 rtl/bin_to_bcd.sv | 77 +++++++
 rtl/display_scheduler.sv | 123 ++++++++++++
 tb/tb_display_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler and its BCD converter.
// Digit codes follow the 7-segment controller: 0-9 numeric, A dash, F blank.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 8;
    localparam int DIGITS_W   = DIGIT_W * NUM_DIGITS;
    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = DIGIT_W * BCD_DIGITS;
    localparam int DWELL_W    = 32;
    localparam int CONV_CNT_W = 8;

    localparam logic [DIGIT_W-1:0]  DIGIT_DASH  = 4'hA;
    localparam logic [DIGIT_W-1:0]  DIGIT_BLANK = 4'hF;
    localparam logic [BIN_W-1:0]    MAX_DISPLAY = 16'd9999;
    localparam logic [DIGITS_W-1:0] DIGITS_RESET = 32'hAAAA_AAAA;

    // Digit 7 carries the source id, 4-6 are blank, 0-3 show the value or dashes.
    function automatic logic [DIGITS_W-1:0] format_digits(
        input logic [4*DIGIT_W-1:0] bcd_low,
        input logic                 over,
        input logic                 src
    );
        logic [DIGITS_W-1:0] f;
        f[31:28] = {3'b000, src};
        f[27:16] = {3{DIGIT_BLANK}};
        f[15:0]  = over ? {4{DIGIT_DASH}} : bcd_low;
        return f;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one shift-add-3 iteration per cycle.
// done_out and bcd_out are combinational so the result is usable in the final iteration cycle.
module bin_to_bcd
    import display_pkg::*;
#(
    parameter int CONV_CYCLES = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic             done_out,
    output logic [BCD_W-1:0] bcd_out
);

    localparam logic [CONV_CNT_W-1:0] LAST_ITER = CONV_CNT_W'(CONV_CYCLES - 1);

    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  busy_q, busy_d;
    logic [CONV_CNT_W-1:0] cnt_q, cnt_d;

    logic [BCD_W-1:0] adj_bcd;
    logic [BCD_W-1:0] step_bcd;
    logic [BIN_W-1:0] step_bin;

    // Add 3 to every BCD digit that would overflow past 9 once doubled.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign adj_bcd[gi*DIGIT_W +: DIGIT_W] =
                (bcd_q[gi*DIGIT_W +: DIGIT_W] >= 4'd5) ?
                bcd_q[gi*DIGIT_W +: DIGIT_W] + 4'd3 :
                bcd_q[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign step_bcd = {adj_bcd[BCD_W-2:0], bin_q[BIN_W-1]};
    assign step_bin = {bin_q[BIN_W-2:0], 1'b0};
    assign bcd_out  = step_bcd;

    always_comb begin
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        done_out = 1'b0;
        if (start_in) begin
            bin_d  = bin_in;
            bcd_d  = '0;
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            bin_d = step_bin;
            bcd_d = step_bcd;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                done_out = 1'b1;
                busy_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin scheduler feeding two binary sources through a BCD converter onto an
// eight-digit display, holding each update for a minimum dwell time.
module display_scheduler
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int CONV_CYCLES  = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                src0_valid_in,
    input  logic [BIN_W-1:0]    src0_data_in,
    output logic                src0_ready_out,
    input  logic                src1_valid_in,
    input  logic [BIN_W-1:0]    src1_data_in,
    output logic                src1_ready_out,
    output logic [DIGITS_W-1:0] digits_out,
    output logic                digits_valid_out,
    output logic                busy_out
);

    localparam logic [DWELL_W-1:0] DWELL_LAST =
        (DWELL_CYCLES > 1) ? DWELL_W'(DWELL_CYCLES - 1) : '0;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                src_q, src_d;
    logic [BIN_W-1:0]    data_q, data_d;
    logic [DIGITS_W-1:0] digits_q, digits_d;
    logic                valid_q, valid_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic             grant1;
    logic             conv_start;
    logic [BIN_W-1:0] conv_bin;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             over_range;

    bin_to_bcd #(
        .CONV_CYCLES(CONV_CYCLES)
    ) u_bin_to_bcd (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start_in(conv_start),
        .bin_in  (conv_bin),
        .done_out(conv_done),
        .bcd_out (conv_bcd)
    );

    // src1 wins when it is the only requester or when src0 was granted last.
    assign grant1     = src1_valid_in && (!src0_valid_in || !last_q);
    assign over_range = (data_q > MAX_DISPLAY) || (conv_bcd[BCD_W-1:16] != 4'd0);

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        src_d          = src_q;
        data_d         = data_q;
        digits_d       = digits_q;
        valid_d        = 1'b0;
        dwell_d        = dwell_q;
        src0_ready_out = 1'b0;
        src1_ready_out = 1'b0;
        conv_start     = 1'b0;
        conv_bin       = grant1 ? src1_data_in : src0_data_in;

        case (state_q)
            ST_IDLE: begin
                if (rst_in && (src0_valid_in || src1_valid_in)) begin
                    src0_ready_out = !grant1;
                    src1_ready_out = grant1;
                    conv_start     = 1'b1;
                    data_d         = conv_bin;
                    src_d          = grant1;
                    last_d         = grant1;
                    state_d        = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    digits_d = format_digits(conv_bcd[15:0], over_range, src_q);
                    valid_d  = 1'b1;
                    dwell_d  = '0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dwell_q >= DWELL_LAST) begin
                    state_d = ST_IDLE;
                end else if (dwell_q != '1) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            src_q    <= 1'b0;
            data_q   <= '0;
            digits_q <= DIGITS_RESET;
            valid_q  <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            src_q    <= src_d;
            data_q   <= data_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            dwell_q  <= dwell_d;
        end
    end

    assign digits_out       = digits_q;
    assign digits_valid_out = valid_q;
    assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Directed scoreboard bench: stimulus pushes expected digits and arrival cycle,
// a negedge monitor pops and compares on every digits_valid_out pulse.
module tb_display_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        src0_valid_in = 1'b0;
    logic [15:0] src0_data_in = '0;
    logic        src0_ready_out;
    logic        src1_valid_in = 1'b0;
    logic [15:0] src1_data_in = '0;
    logic        src1_ready_out;
    logic [31:0] digits_out;
    logic        digits_valid_out;
    logic        busy_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] digits;
        int          cycle;
    } exp_t;
    exp_t exp_q[$];

    display_scheduler #(
        .DWELL_CYCLES(4),
        .CONV_CYCLES (16)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .src0_valid_in   (src0_valid_in),
        .src0_data_in    (src0_data_in),
        .src0_ready_out  (src0_ready_out),
        .src1_valid_in   (src1_valid_in),
        .src1_data_in    (src1_data_in),
        .src1_ready_out  (src1_ready_out),
        .digits_out      (digits_out),
        .digits_valid_out(digits_valid_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (digits_valid_out) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got digits=%h at cycle %0d, required no pulse", digits_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (digits_out !== e.digits || cyc != e.cycle) begin
                    bad++;
                    $display("FAIL digits: got %h at cycle %0d, required %h at cycle %0d",
                             digits_out, cyc, e.digits, e.cycle);
                end else begin
                    $display("ok digits %h at cycle %0d", digits_out, cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end else begin
            $display("ok %s = %h", name, got);
        end
    endtask

    // Sample 1 time unit after each rising edge until the scheduler returns to IDLE.
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_in);
            #1;
            if (!busy_out) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: busy_out still 1 after 100 cycles, required 0");
    endtask

    // Called #1 after a rising edge with valids already set and visible.
    task automatic transfer(input logic [31:0] want_digits);
        @(posedge clk_in);
        #1;
        exp_q.push_back('{digits: want_digits, cycle: cyc + 16});
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b0;
        repeat (n) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    initial begin
        // Reset state and quiet idle period.
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_digits", digits_out, 32'hAAAA_AAAA);
        check("reset_busy", {31'd0, busy_out}, 32'd0);
        check("reset_valid", {31'd0, digits_valid_out}, 32'd0);
        rst_in = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        check("idle_digits", digits_out, 32'hAAAA_AAAA);

        // Single src0 request.
        src0_valid_in = 1'b1;
        src0_data_in  = 16'd1234;
        #1;
        check("s0_ready", {30'd0, src1_ready_out, src0_ready_out}, 32'd1);
        transfer(32'h0FFF_1234);
        src0_valid_in = 1'b0;
        check("s0_busy", {31'd0, busy_out}, 32'd1);
        wait_idle();
        check("s0_hold_digits", digits_out, 32'h0FFF_1234);

        // Round-robin with both sources continuously valid, fresh pointer.
        do_reset(2);
        src0_valid_in = 1'b1;
        src0_data_in  = 16'd42;
        src1_valid_in = 1'b1;
        src1_data_in  = 16'd9876;
        #1;
        check("rr_grant0", {30'd0, src1_ready_out, src0_ready_out}, 32'd1);
        transfer(32'h0FFF_0042);
        wait_idle();
        check("rr_grant1", {30'd0, src1_ready_out, src0_ready_out}, 32'd2);
        transfer(32'h1FFF_9876);
        wait_idle();
        check("rr_grant2", {30'd0, src1_ready_out, src0_ready_out}, 32'd1);
        transfer(32'h0FFF_0042);
        src0_valid_in = 1'b0;
        src1_valid_in = 1'b0;
        wait_idle();

        // Over-range value from src1 shows dashes.
        src1_valid_in = 1'b1;
        src1_data_in  = 16'd10000;
        #1;
        check("ovr_ready", {30'd0, src1_ready_out, src0_ready_out}, 32'd2);
        transfer(32'h1FFF_AAAA);
        src1_valid_in = 1'b0;
        wait_idle();
        check("ovr_hold_digits", digits_out, 32'h1FFF_AAAA);

        // src0 requests while busy: must wait for the first IDLE cycle.
        src1_valid_in = 1'b1;
        src1_data_in  = 16'd5;
        #1;
        transfer(32'h1FFF_0005);
        src1_valid_in = 1'b0;
        src0_valid_in = 1'b1;
        src0_data_in  = 16'd7;
        begin
            int leaked = 0;
            int waited = 0;
            while (busy_out && waited < 100) begin
                if (src0_ready_out || src1_ready_out) leaked++;
                @(posedge clk_in);
                #1;
                waited++;
            end
            check("busy_ready_leak", leaked, 32'd0);
        end
        check("late_ready", {30'd0, src1_ready_out, src0_ready_out}, 32'd1);
        transfer(32'h0FFF_0007);
        src0_valid_in = 1'b0;
        wait_idle();

        // Reset 5 cycles into a conversion: no pulse, digits back to dashes.
        src0_valid_in = 1'b1;
        src0_data_in  = 16'd555;
        #1;
        @(posedge clk_in);
        #1;
        src0_valid_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        rst_in        = 1'b0;
        src0_valid_in = 1'b1;
        #1;
        check("rst_ready", {30'd0, src1_ready_out, src0_ready_out}, 32'd0);
        @(posedge clk_in);
        #1;
        check("rst_abort_digits", digits_out, 32'hAAAA_AAAA);
        check("rst_abort_busy", {31'd0, busy_out}, 32'd0);
        src0_valid_in = 1'b0;
        rst_in        = 1'b1;
        repeat (40) @(posedge clk_in);
        #1;
        check("post_rst_digits", digits_out, 32'hAAAA_AAAA);

        check("pending_expect", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
